// File: rtl/msg_scroll_ctrl.sv
// Message scroller sequencer: holds a writable character message and steps a
// display window across NUM_DIGITS seven-segment digits at a selectable rate.
module msg_scroll_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned BLANK_CODE = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_pause,
  input  logic                         i_dir,
  input  logic [1:0]                   i_speed,
  input  logic                         i_wr_en,
  input  logic [3:0]                   i_wr_addr,
  input  logic [CODE_W-1:0]            i_wr_code,
  output logic [NUM_DIGITS*CODE_W-1:0] o_codes,
  output logic [1:0]                   o_state,
  output logic                         o_wrap
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned SW = AW + 1;
  localparam int unsigned DW = $clog2(CLK_HZ);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]        r_state;
  logic [AW-1:0]     r_idx;
  logic [DW-1:0]     r_div;
  logic              r_wrap;
  logic [CODE_W-1:0] r_msg [MSG_LEN];

  logic [1:0]        w_state_nxt;
  logic [AW-1:0]     w_idx_nxt;
  logic [DW-1:0]     w_div_nxt;
  logic              w_wrap_nxt;
  logic [DW-1:0]     w_limit;
  logic [AW-1:0]     w_idx_step;
  logic              w_wraps;
  logic [SW-1:0]     w_sum;

  // Terminal divider count for the selected speed
  always_comb begin
    w_limit = DW'(CLK_HZ - 1);
    case (i_speed)
      2'd0:    w_limit = DW'(CLK_HZ - 1);
      2'd1:    w_limit = DW'((CLK_HZ >> 1) - 1);
      2'd2:    w_limit = DW'((CLK_HZ >> 2) - 1);
      default: w_limit = DW'((CLK_HZ >> 3) - 1);
    endcase
  end

  // Candidate index for the next step in the sampled direction
  always_comb begin
    w_wraps    = 1'b0;
    w_idx_step = r_idx;
    if (!i_dir) begin
      w_wraps    = (r_idx == AW'(MSG_LEN - 1));
      w_idx_step = w_wraps ? '0 : r_idx + AW'(1);
    end else begin
      w_wraps    = (r_idx == '0);
      w_idx_step = w_wraps ? AW'(MSG_LEN - 1) : r_idx - AW'(1);
    end
  end

  // Next-state logic: stop beats start beats pause
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_stop && i_start) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end else if (i_start) begin
          w_idx_nxt = '0;
          w_div_nxt = '0;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSED;
        end else if (r_div >= w_limit) begin
          w_div_nxt  = '0;
          w_idx_nxt  = w_idx_step;
          w_wrap_nxt = w_wraps;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      S_PAUSED: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end else if (i_start) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end else if (!i_pause) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_div_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_div   <= '0;
      r_wrap  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_div   <= w_div_nxt;
      r_wrap  <= w_wrap_nxt;
      // Out-of-range addresses match no entry and are dropped
      for (int i = 0; i < MSG_LEN; i++) begin
        if (i_wr_en && (i_wr_addr == 4'(i))) r_msg[i] <= i_wr_code;
      end
    end
  end

  // Leftmost digit shows msg[idx]; each digit to the right shows the next entry
  always_comb begin
    o_codes = {NUM_DIGITS{CODE_W'(BLANK_CODE)}};
    w_sum   = '0;
    if (r_state != S_IDLE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        w_sum = SW'(r_idx) + SW'((NUM_DIGITS - 1 - k) % MSG_LEN);
        if (w_sum >= SW'(MSG_LEN)) w_sum = w_sum - SW'(MSG_LEN);
        o_codes[k*CODE_W +: CODE_W] = r_msg[AW'(w_sum)];
      end
    end
  end

  assign o_state = r_state;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// Scoreboard bench for msg_scroll_ctrl: a cycle-level reference model pushes
// expected outputs; an independent monitor pops and compares every cycle.
module tb_msg_scroll_ctrl;

  localparam int unsigned CLK_HZ  = 16;
  localparam int unsigned MSG_LEN = 8;
  localparam int unsigned ND      = 6;
  localparam int unsigned CW      = 3;
  localparam int unsigned BLANK   = 7;
  localparam int unsigned OW      = ND * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_dir = 1'b0;
  logic [1:0]    i_speed = 2'd0;
  logic          i_wr_en = 1'b0;
  logic [3:0]    i_wr_addr = 4'd0;
  logic [CW-1:0] i_wr_code = '0;
  logic [OW-1:0] o_codes;
  logic [1:0]    o_state;
  logic          o_wrap;

  msg_scroll_ctrl #(.CLK_HZ(CLK_HZ), .MSG_LEN(MSG_LEN), .NUM_DIGITS(ND),
                    .CODE_W(CW), .BLANK_CODE(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_pause(i_pause), .i_dir(i_dir), .i_speed(i_speed), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_code(i_wr_code), .o_codes(o_codes),
    .o_state(o_state), .o_wrap(o_wrap));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic [OW-1:0] codes;
    logic          wrap;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: 0 idle, 1 run, 2 paused
  int m_state = 0, m_idx = 0, m_div = 0;
  bit m_wrap = 1'b0;
  int m_msg[MSG_LEN];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st   = 2'(m_state);
    e.wrap = m_wrap;
    for (int k = 0; k < ND; k++) begin
      if (m_state == 0) e.codes[k*CW +: CW] = CW'(BLANK);
      else e.codes[k*CW +: CW] = CW'(m_msg[(m_idx + ND - 1 - k) % MSG_LEN]);
    end
    return e;
  endfunction

  task automatic model_step();
    int lim;
    int old_idx;
    if (!rst_n) begin
      m_state = 0; m_idx = 0; m_div = 0; m_wrap = 1'b0;
      for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 0;
      return;
    end
    m_wrap = 1'b0;
    lim = (CLK_HZ >> i_speed) - 1;
    if (m_state == 0) begin
      if (!i_stop && i_start) begin m_state = 1; m_idx = 0; m_div = 0; end
    end else if (i_stop) begin
      m_state = 0; m_idx = 0; m_div = 0;
    end else if (i_start) begin
      m_state = 1; m_idx = 0; m_div = 0;
    end else if (m_state == 2) begin
      if (!i_pause) m_state = 1;
    end else if (i_pause) begin
      m_state = 2;
    end else if (m_div >= lim) begin
      m_div = 0;
      old_idx = m_idx;
      m_idx = (m_idx + (i_dir ? MSG_LEN - 1 : 1)) % MSG_LEN;
      m_wrap = i_dir ? (old_idx == 0) : (m_idx == 0);
    end else begin
      m_div++;
    end
    if (i_wr_en && i_wr_addr < MSG_LEN) m_msg[i_wr_addr] = int'(i_wr_code);
  endtask

  // One clock: model follows the edge, then one-cycle pulses are released
  task automatic tick();
    @(posedge clk);
    model_step();
    q.push_back(model_out());
    @(negedge clk);
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_msg();
    for (int i = 0; i < MSG_LEN; i++) begin
      i_wr_en = 1'b1; i_wr_addr = 4'(i); i_wr_code = CW'(i);
      tick();
    end
  endtask

  // Monitor: compares every presented output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_state", 32'(o_state), 32'(e.st));
        chk("sb_codes", 32'(o_codes), 32'(e.codes));
        chk("sb_wrap",  32'(o_wrap),  32'(e.wrap));
      end
    end
  end

  initial begin
    logic [OW-1:0] seq012345, seq701234, seq123456, seq234567, all_blank;
    seq012345 = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    seq701234 = {3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    seq123456 = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    seq234567 = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    all_blank = {ND{3'd7}};

    #1 rst_n = 1'b0;
    ticks(2);
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_codes", 32'(o_codes), 32'(all_blank));
    chk("reset_wrap",  32'(o_wrap),  32'd0);
    rst_n = 1'b1;
    load_msg();

    // Start and full left-scroll lap at speed 0
    i_start = 1'b1; tick();
    chk("start_state", 32'(o_state), 32'd1);
    chk("start_codes", 32'(o_codes), 32'(seq012345));
    ticks(8 * 16);
    chk("lap_wrap",  32'(o_wrap),  32'd1);
    chk("lap_codes", 32'(o_codes), 32'(seq012345));

    // Fast right scroll from index 0 wraps to 7
    i_start = 1'b1; i_speed = 2'd3; i_dir = 1'b1; tick();
    ticks(2);
    chk("right_wrap",  32'(o_wrap),  32'd1);
    chk("right_codes", 32'(o_codes), 32'(seq701234));

    // Pause mid-period keeps the divider phase
    i_start = 1'b1; i_speed = 2'd0; i_dir = 1'b0; tick();
    ticks(16 + 10);
    i_pause = 1'b1;
    ticks(40);
    chk("paused_state", 32'(o_state), 32'd2);
    i_pause = 1'b0;
    ticks(6);
    chk("resume_hold_codes", 32'(o_codes), 32'(seq123456));
    tick();
    chk("resume_step_codes", 32'(o_codes), 32'(seq234567));

    // Stop beats start; writes out of range ignored, in range visible
    i_start = 1'b1; i_stop = 1'b1; tick();
    chk("stop_state", 32'(o_state), 32'd0);
    chk("stop_codes", 32'(o_codes), 32'(all_blank));
    i_wr_en = 1'b1; i_wr_addr = 4'd9; i_wr_code = 3'd3; tick();
    i_start = 1'b1; tick();
    i_wr_en = 1'b1; i_wr_addr = 4'd2; i_wr_code = 3'd5; tick();
    chk("write_digit3", 32'(o_codes[11:9]), 32'd5);
    chk("oob_digit4",   32'(o_codes[14:12]), 32'd1);

    // Async reset mid-scroll clears everything
    i_speed = 2'd3; i_start = 1'b1; tick();
    ticks(8);
    rst_n = 1'b0; tick();
    chk("midrst_state", 32'(o_state), 32'd0);
    chk("midrst_codes", 32'(o_codes), 32'(all_blank));
    chk("midrst_wrap",  32'(o_wrap),  32'd0);
    rst_n = 1'b1; i_start = 1'b1; tick();
    chk("midrst_msg_cleared", 32'(o_codes), 32'd0);

    // Randomized phase
    load_msg();
    for (int c = 0; c < 3000; c++) begin
      i_start = ($urandom_range(0, 99) < 2);
      i_stop  = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 99) < 3) i_pause = ~i_pause;
      if ($urandom_range(0, 99) < 5) i_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) i_speed = 2'($urandom_range(0, 3));
      i_wr_en   = ($urandom_range(0, 99) < 10);
      i_wr_addr = 4'($urandom_range(0, 15));
      i_wr_code = CW'($urandom_range(0, 7));
      rst_n     = ($urandom_range(0, 999) != 0);
      tick();
      rst_n = 1'b1;
    end

    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
